// File: rtl/nmea_sentence_filter.sv
// nmea_sentence_filter: buffers one NMEA sentence, verifies its XOR checksum, replays it on success.
// Define NMEA_CKSUM_CHECK_EN to enforce the checksum compare; otherwise every well-formed sentence passes.
module nmea_sentence_filter #(
    parameter int MAX_LEN   = 82,
    parameter int ADDR_BITS = 7
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic       out_eof,
    output logic       sent_ok,
    output logic       sent_err,
    output logic [7:0] err_count
);
    typedef enum logic [2:0] {IDLE, COLLECT, CK_HI, CK_LO, CHECK, REPLAY} state_t;

    localparam logic [ADDR_BITS:0]   LEN_MAX = (ADDR_BITS + 1)'(MAX_LEN);
    localparam logic [ADDR_BITS:0]   ONE_L   = 1;
    localparam logic [ADDR_BITS-1:0] ONE_A   = 1;
`ifdef NMEA_CKSUM_CHECK_EN
    localparam logic CK_EN = 1'b1;
`else
    localparam logic CK_EN = 1'b0;
`endif

    state_t                 r_state, w_next;
    logic [ADDR_BITS:0]     r_len;
    logic [ADDR_BITS-1:0]   r_rd;
    logic [7:0]             r_acc, r_ck, r_err_cnt;
    logic [7:0]             r_buf [0:(1<<ADDR_BITS)-1];
    logic                   w_xfer, w_dollar, w_star, w_hex, w_full, w_store, w_match;
    logic [3:0]             w_nib;
    logic [ADDR_BITS-1:0]   w_last;

    assign in_ready  = (r_state != CHECK) && (r_state != REPLAY);
    assign out_valid = (r_state == REPLAY);
    assign out_data  = out_valid ? r_buf[r_rd] : 8'h00;
    assign w_last    = r_len[ADDR_BITS-1:0] - ONE_A;
    assign out_sof   = out_valid && (r_rd == '0);
    assign out_eof   = out_valid && (r_rd == w_last);
    assign err_count = r_err_cnt;

    assign w_xfer   = in_valid && in_ready;
    assign w_dollar = (in_data == 8'h24);
    assign w_star   = (in_data == 8'h2A);
    assign w_hex    = (in_data >= 8'h30 && in_data <= 8'h39) ||
                      (in_data >= 8'h41 && in_data <= 8'h46) ||
                      (in_data >= 8'h61 && in_data <= 8'h66);
    // letters A-F / a-f share low nibbles 1..6, so +9 maps both cases to 10..15
    assign w_nib    = (in_data <= 8'h39) ? in_data[3:0] : in_data[3:0] + 4'd9;
    assign w_full   = (r_len >= LEN_MAX);
    assign w_store  = w_xfer && (r_state == COLLECT) && !w_dollar && !w_star && !w_full;
    assign w_match  = !CK_EN || (r_acc == r_ck);

    always_comb begin
        w_next   = r_state;
        sent_ok  = 1'b0;
        sent_err = 1'b0;
        case (r_state)
            IDLE: if (w_xfer && w_dollar) w_next = COLLECT;
            COLLECT: if (w_xfer) begin
                if (w_dollar) begin
                    sent_err = 1'b1;
                end else if (w_star) begin
                    w_next = CK_HI;
                end else if (w_full) begin
                    sent_err = 1'b1;
                    w_next   = IDLE;
                end
            end
            CK_HI, CK_LO: if (w_xfer) begin
                if (w_dollar) begin
                    sent_err = 1'b1;
                    w_next   = COLLECT;
                end else if (!w_hex) begin
                    sent_err = 1'b1;
                    w_next   = IDLE;
                end else begin
                    w_next = (r_state == CK_HI) ? CK_LO : CHECK;
                end
            end
            CHECK: begin
                sent_ok  = w_match;
                sent_err = !w_match;
                w_next   = w_match ? REPLAY : IDLE;
            end
            REPLAY: if (out_ready && out_eof) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_acc     <= '0;
            r_ck      <= '0;
            r_rd      <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer && w_dollar) begin
                r_len <= ONE_L;
                r_acc <= '0;
            end else if (w_store) begin
                r_len <= r_len + ONE_L;
                r_acc <= r_acc ^ in_data;
            end
            if (w_xfer && r_state == CK_HI) r_ck[7:4] <= w_nib;
            if (w_xfer && r_state == CK_LO) r_ck[3:0] <= w_nib;
            if (r_state != REPLAY) r_rd <= '0;
            else if (out_ready) r_rd <= r_rd + ONE_A;
            if (sent_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // sentence storage carries no reset; a '$' always lands at address 0
    always_ff @(posedge clk_50MHz) begin
        if (w_xfer && w_dollar) r_buf[0] <= in_data;
        else if (w_store) r_buf[r_len[ADDR_BITS-1:0]] <= in_data;
    end
endmodule
